// File: rtl/axi_word_responder_pkg.sv
// Shared types and constants for the single-beat AXI4-Lite-style word responder.
// Holds the responder FSM state enum, the AXI response codes and the
// default-configuration widths used as sub-module parameter defaults.
package axi_word_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    R_WAIT,
    R_RESP,
    W_WAIT,
    W_RESP
  } t_resp_state;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widths for the default 256 x 32-bit configuration.
  localparam int WORD_IDX_W = 8;
  localparam int STRB_W     = 4;

endpackage

// File: rtl/axi_word_ram.sv
// Byte-strobed word RAM: synchronous write, registered read, contents not reset.
// Ports: clk; we/waddr/wdata/wstrb write port; re/raddr read port, rdata
// updates only on an edge where re=1 and otherwise holds its last value.
module axi_word_ram
  import axi_word_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 256,
  parameter int IDX_W  = WORD_IDX_W,
  parameter int BYTES  = STRB_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BYTES-1:0]  wstrb,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BYTES; k++) begin
        if (wstrb[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_word_responder.sv
// Memory-side single-beat AXI4-Lite-style responder backed by a word RAM,
// with a programmable request-to-response latency (LATENCY idle cycles).
// Ports: clk, arst (async, active-low); AR/R read channel; AW/W/B write
// channel. Optional macro AXI_WORD_RESP_ERR_EN: out-of-range accesses
// answer SLVERR (read data 0, write dropped) instead of aliasing.
module axi_word_responder
  import axi_word_responder_pkg::*;
#(
  parameter int                          AXI_DATA_WIDTH = 32,
  parameter int                          AXI_ADDR_WIDTH = 64,
  parameter int                          MEM_WORDS      = 256,
  parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
  parameter int                          LATENCY        = 2
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        i_arvalid,
  output logic                        o_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_araddr,
  output logic                        o_rvalid,
  input  logic                        i_rready,
  output logic [AXI_DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]                  o_rresp,
  input  logic                        i_awvalid,
  output logic                        o_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                        i_wvalid,
  output logic                        o_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
  output logic                        o_bvalid,
  input  logic                        i_bready,
  output logic [1:0]                  o_bresp
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int SW = AXI_DATA_WIDTH / 8;

  t_resp_state state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  rresp_q, rresp_n, bresp_q, bresp_n;
  logic        rzero_q, rzero_n;
  logic        ready_en;
  logic        ram_we, ram_re;
  logic [AXI_DATA_WIDTH-1:0] ram_q;

  logic [AXI_ADDR_WIDTH-1:0] ar_off, aw_off;
  logic                      ar_err, aw_err;

  assign ar_off = i_araddr - BASE_ADDR;
  assign aw_off = i_awaddr - BASE_ADDR;

`ifdef AXI_WORD_RESP_ERR_EN
  // off >= MEM_WORDS*4 is exactly "any bit above the byte span is set".
  assign ar_err = |ar_off[AXI_ADDR_WIDTH-1:IW+2];
  assign aw_err = |aw_off[AXI_ADDR_WIDTH-1:IW+2];
  logic unused_off;
  assign unused_off = ^{ar_off[1:0], aw_off[1:0]};
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
  logic unused_off;
  assign unused_off = ^{ar_off[AXI_ADDR_WIDTH-1:IW+2], ar_off[1:0],
                        aw_off[AXI_ADDR_WIDTH-1:IW+2], aw_off[1:0]};
`endif

  axi_word_ram #(
    .DATA_W (AXI_DATA_WIDTH),
    .WORDS  (MEM_WORDS),
    .IDX_W  (IW),
    .BYTES  (SW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (aw_off[IW+1:2]),
    .wdata (i_wdata),
    .wstrb (i_wstrb),
    .re    (ram_re),
    .raddr (ar_off[IW+1:2]),
    .rdata (ram_q)
  );

  // The RAM output register has no reset, so a reset-able flag forces the
  // read data to zero after reset and for out-of-range reads.
  assign o_rdata = rzero_q ? '0 : ram_q;
  assign o_rresp = rresp_q;
  assign o_bresp = bresp_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state    <= IDLE;
      cnt      <= '0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
      rzero_q  <= 1'b1;
      ready_en <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rresp_q  <= rresp_n;
      bresp_q  <= bresp_n;
      rzero_q  <= rzero_n;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rresp_n   = rresp_q;
    bresp_n   = bresp_q;
    rzero_n   = rzero_q;
    o_arready = 1'b0;
    o_awready = 1'b0;
    o_rvalid  = 1'b0;
    o_bvalid  = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state)
      IDLE: begin
        // ready_en keeps every ready low while reset is asserted.
        o_arready = ready_en;
        o_awready = ready_en & ~i_arvalid;
        cnt_n     = 4'(LATENCY);
        if (ready_en && i_arvalid) begin
          ram_re  = 1'b1;
          rzero_n = ar_err;
          rresp_n = ar_err ? RESP_SLVERR : RESP_OKAY;
          state_n = (LATENCY == 0) ? R_RESP : R_WAIT;
        end else if (ready_en && i_awvalid && i_wvalid) begin
          ram_we  = ~aw_err;
          bresp_n = aw_err ? RESP_SLVERR : RESP_OKAY;
          state_n = (LATENCY == 0) ? W_RESP : W_WAIT;
        end
      end
      // The wait state lasts exactly LATENCY cycles: leave on the cycle the
      // decremented count reaches zero.
      R_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = R_RESP;
      end
      W_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = W_RESP;
      end
      R_RESP: begin
        o_rvalid = 1'b1;
        if (i_rready) state_n = IDLE;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_wready = o_awready;

endmodule

// File: doc/axi_word_responder.md
Name: axi_word_responder

Overview:
- Memory-side AXI4-Lite-style single-beat responder; the other end of the cache data-transfer path, which issues one word per handshake with a +4 address stride.
- Backs a word-addressed RAM and serves read (AR/R) and write (AW/W/B) channels.
- Response latency is programmable, so the cache-side counter and address-increment logic can be exercised against realistic slave timing.
- Used as the memory model in subsystem sims and as the on-chip scratch RAM.

Parameters:
- AXI_DATA_WIDTH, 32: data word width; must be a multiple of 8.
- AXI_ADDR_WIDTH, 64: address width.
- MEM_WORDS, 256: RAM depth in words; must be a power of 2.
- BASE_ADDR, 64'h0: byte address of word 0.
- LATENCY, 2: idle cycles between request acceptance and response valid (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst  in  1  asynchronous reset, active-low.
- i_arvalid  in  1  read address valid.
- o_arready  out  1  read address ready.
- i_araddr  in  AXI_ADDR_WIDTH  read byte address.
- o_rvalid  out  1  read data valid.
- i_rready  in  1  read data ready.
- o_rdata  out  AXI_DATA_WIDTH  read data.
- o_rresp  out  2  read response.
- i_awvalid  in  1  write address valid.
- o_awready  out  1  write address ready.
- i_awaddr  in  AXI_ADDR_WIDTH  write byte address.
- i_wvalid  in  1  write data valid.
- o_wready  out  1  write data ready.
- i_wdata  in  AXI_DATA_WIDTH  write data.
- i_wstrb  in  AXI_DATA_WIDTH/8  byte strobes.
- o_bvalid  out  1  write response valid.
- i_bready  in  1  write response ready.
- o_bresp  out  2  write response.

Behaviour:
- Reset (arst=0, asynchronous):
  - FSM goes to IDLE; all ready and valid outputs 0; o_rdata 0; o_rresp 00; o_bresp 00; latency counter 0.
  - RAM contents are not reset.
- FSM states: IDLE, R_WAIT, R_RESP, W_WAIT, W_RESP.
- IDLE:
  - o_arready=1.
  - o_awready = o_wready = !i_arvalid, i.e. read wins when both requests are pending.
  - Read accept (i_arvalid & o_arready): capture RAM word into the rdata register, load counter=LATENCY, go to R_WAIT.
  - Write accept requires i_awvalid & i_wvalid together; AW and W are never accepted separately.
    - On the accepting edge, write RAM bytes where wstrb[k]=1.
    - Load counter=LATENCY, go to W_WAIT.
- R_WAIT / W_WAIT: decrement the counter each cycle; when it reads 0, go to R_RESP / W_RESP.
- Timing: request accepted at edge T gives valid high from cycle T+1+LATENCY. With LATENCY=0, valid is high in the cycle after acceptance.
- R_RESP: o_rvalid=1; o_rdata and o_rresp are held stable until i_rready; then return to IDLE.
- W_RESP: o_bvalid=1 until i_bready; then return to IDLE.
- All readies are 0 outside IDLE. Back-to-back rate is one transaction per 2+LATENCY cycles.
- Address mapping:
  - off = addr - BASE_ADDR (AXI_ADDR_WIDTH-bit wrapping subtract).
  - Word index = off[$clog2(MEM_WORDS)+1:2].
  - Address bits [1:0] are ignored; unaligned accesses are treated as aligned.
- Read after write to the same word returns the new data; the write has committed before any later read can be accepted.
- Default response is OKAY (00).
- Valid/ready already high when a state is entered: the handshake completes that cycle, with no extra delay.

Optional Feature:
- Macro AXI_WORD_RESP_ERR_EN.
- Defined: an access is out of range when off >= MEM_WORDS*4 (includes addr < BASE_ADDR via wrap).
  - Out-of-range read: rresp=SLVERR (10), rdata=0.
  - Out-of-range write: RAM unchanged, bresp=SLVERR.
  - Latency is the same as for an in-range access.
- Undefined: out-of-range addresses alias modulo MEM_WORDS; responses are always OKAY.

Decomposition:
- Shared package holds:
  - state enum `t_resp_state`;
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - localparams WORD_IDX_W and STRB_W.
- One sub-module, `axi_word_ram`: byte-strobed synchronous-write, registered-read word RAM, no reset.
- FSM and latency counter live in the top level.

Test Plan:
- Write then read, LATENCY=2, BASE=0:
  - Write addr 0x10, data 0xDEADBEEF, strb 1111 -> bvalid exactly 3 cycles after accept, bresp 00.
  - Read 0x10 -> rdata 0xDEADBEEF, rvalid 3 cycles after AR accept.
- Partial strobe: word 0x20 = 0x11223344; write 0xAABBCCDD with strb 0101 -> read returns 0x11BB3DD... per byte, i.e. 0x11BB33DD.
- Simultaneous arvalid and awvalid+wvalid in IDLE -> read accepted first (arready=1, awready=0); write accepted in the first IDLE after the R handshake.
- Backpressure: hold i_rready=0 for 5 cycles -> rvalid, rdata, rresp stable; no new AR accepted. LATENCY=0 -> rvalid the cycle after accept.
- Reset mid-transaction: arst=0 in W_WAIT -> bvalid and all readies 0 immediately. After release, the state is IDLE and the earlier committed write is still readable.
- With AXI_WORD_RESP_ERR_EN, MEM_WORDS=256:
  - Read 0x400 -> rresp 10, rdata 0.
  - Write 0x400 -> bresp 10; word 0 unchanged.
  - Without the macro, read 0x400 returns word 0, rresp 00.
